i2c_register_writer: RTL

- Downstream consumer of i2c_slave_serializer. Takes its strobed byte stream plus start/stop flags.
- Decodes the I2C address byte and a register-pointer byte, then writes the following data bytes into a shadow register file with pointer auto-increment.
- On a stop condition it commits the shadow file atomically to a parallel output bus (e.g. pwm16 duty_cycle), so consumers never see a half-written multi-byte value.

---
 rtl/i2c_register_writer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_register_writer.sv
// I2C register writer: decodes address and pointer bytes from the slave serializer,
// fills a shadow register file, and commits it atomically to the output on stop.
module i2c_register_writer #(
    parameter int unsigned                NUM_REGS    = 2,
    parameter logic [6:0]                 I2C_ADDRESS = 7'h42,
    parameter logic [NUM_REGS*8-1:0]      RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     wr,
    input  logic [7:0]               write_data,
    output logic [NUM_REGS*8-1:0]    out,
    output logic                     update,
    output logic                     addressed,
    output logic                     overrun
);

    localparam int unsigned OUT_W = NUM_REGS * 8;
    localparam int unsigned PTR_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        POINTER = 3'd2,
        DATA    = 3'd3,
        IGNORE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [OUT_W-1:0]   r_shadow;
    logic [OUT_W-1:0]   w_shadow_nxt;
    logic               r_dirty;
    logic               w_dirty_nxt;
    logic [OUT_W-1:0]   r_out;
    logic [OUT_W-1:0]   w_out_nxt;
    logic               r_update;
    logic               w_update_nxt;
    logic               r_addressed;
    logic               w_addressed_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic               w_ptr_valid;
    logic               w_addr_match;

    assign w_ptr_valid  = (32'(r_ptr) < NUM_REGS);
    assign w_addr_match = (write_data[7:1] == I2C_ADDRESS) && !write_data[0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath: stop beats start beats wr
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_shadow_nxt    = r_shadow;
        w_dirty_nxt     = r_dirty;
        w_out_nxt       = r_out;
        w_update_nxt    = 1'b0;
        w_addressed_nxt = r_addressed;
        w_overrun_nxt   = r_overrun;

        if (stop) begin
            if ((r_state == DATA || r_state == POINTER) && r_dirty) begin
                w_out_nxt    = r_shadow;
                w_update_nxt = 1'b1;
            end
            w_dirty_nxt     = 1'b0;
            w_addressed_nxt = 1'b0;
            w_state_nxt     = start ? ADDR : IDLE;
        end else if (start) begin
            // Repeated start keeps shadow contents and dirty for the next stop
            w_state_nxt     = ADDR;
            w_addressed_nxt = 1'b0;
        end else if (wr) begin
            case (r_state)
                ADDR: begin
                    if (w_addr_match) begin
                        w_state_nxt     = POINTER;
                        w_addressed_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IGNORE;
                    end
                end
                POINTER: begin
                    w_ptr_nxt   = write_data;
                    w_state_nxt = DATA;
                end
                DATA: begin
                    if (w_ptr_valid) begin
                        for (int unsigned k = 0; k < NUM_REGS; k++) begin
                            if (32'(r_ptr) == k) begin
                                w_shadow_nxt[k*8 +: 8] = write_data;
                            end
                        end
                        w_dirty_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = 1'b1;
                    end
                    w_ptr_nxt = r_ptr + 8'd1;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_shadow    <= RESET_VALUE;
            r_dirty     <= 1'b0;
            r_out       <= RESET_VALUE;
            r_update    <= 1'b0;
            r_addressed <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_shadow    <= w_shadow_nxt;
            r_dirty     <= w_dirty_nxt;
            r_out       <= w_out_nxt;
            r_update    <= w_update_nxt;
            r_addressed <= w_addressed_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign out       = r_out;
    assign update    = r_update;
    assign addressed = r_addressed;
    assign overrun   = r_overrun;

endmodule
